// File: rtl/hazard_sequencer_if.sv
// Pipeline-side hazard signals and the front-end control outputs of the hazard sequencer.
// The sequencer uses the slave view; the pipeline (or a bench) uses the master view.
interface hazard_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ID_Ex_MemRead;
  logic             ID_Ex_RegWrite;
  logic [4:0]       ID_Ex_wreg;
  logic             Ex_Mem_MemRead;
  logic [4:0]       Ex_Mem_wreg;
  logic [4:0]       IF_ID_rs;
  logic [4:0]       IF_ID_rt;
  logic             IF_ID_Branch;
  logic             Branch_taken;
  logic             Jump;
  logic             mem_busy;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_Ex_Flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output ID_Ex_MemRead, ID_Ex_RegWrite, ID_Ex_wreg, Ex_Mem_MemRead, Ex_Mem_wreg,
    output IF_ID_rs, IF_ID_rt, IF_ID_Branch, Branch_taken, Jump, mem_busy,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_Ex_Flush, stall_cycles, flush_events
  );

  modport slave (
    input  ID_Ex_MemRead, ID_Ex_RegWrite, ID_Ex_wreg, Ex_Mem_MemRead, Ex_Mem_wreg,
    input  IF_ID_rs, IF_ID_rt, IF_ID_Branch, Branch_taken, Jump, mem_busy,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_Ex_Flush, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage MIPS front end: multi-cycle load/branch bubbles,
// wrong-path squash on taken branch/jump, full freeze while data memory is busy.
module hazard_sequencer #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned LD_BR_BUBBLES = 2
) (
  input logic         clk,
  input logic         rst,
  hazard_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StRun, StStall, StFreeze} state_e;

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  logic [1:0]       rem_q, rem_d;
  logic [1:0]       n_req;
  logic             ex_match, mem_match;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Register 0 is hardwired, so it never creates a dependency.
  assign ex_match  = (bus.ID_Ex_wreg != 5'd0) &&
                     (bus.ID_Ex_wreg == bus.IF_ID_rs || bus.ID_Ex_wreg == bus.IF_ID_rt);
  assign mem_match = (bus.Ex_Mem_wreg != 5'd0) &&
                     (bus.Ex_Mem_wreg == bus.IF_ID_rs || bus.Ex_Mem_wreg == bus.IF_ID_rt);

  always_comb begin
    n_req = 2'd0;
    if (bus.IF_ID_Branch && bus.ID_Ex_RegWrite && ex_match) begin
      n_req = bus.ID_Ex_MemRead ? 2'(LD_BR_BUBBLES) : 2'd1;
    end else if (bus.IF_ID_Branch && bus.Ex_Mem_MemRead && mem_match) begin
      n_req = 2'd1;
    end else if (!bus.IF_ID_Branch && bus.ID_Ex_MemRead && ex_match) begin
      n_req = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      ret_q   <= StRun;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    rem_d   = rem_q;
    unique case (state_q)
      StRun: begin
        if (bus.mem_busy) begin
          state_d = StFreeze;
          ret_d   = StRun;
        end else if (n_req > 2'd1) begin
          state_d = StStall;
          rem_d   = n_req - 2'd1;
        end
      end
      StStall: begin
        if (bus.mem_busy) begin
          state_d = StFreeze;
          ret_d   = StStall;
        end else begin
          rem_d = rem_q - 2'd1;
          if (rem_q <= 2'd1) state_d = StRun;
        end
      end
      StFreeze: begin
        // The release cycle still shows freeze outputs; rem resumes untouched.
        if (!bus.mem_busy) state_d = ret_q;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    bus.PC_Write    = 1'b1;
    bus.IF_ID_Write = 1'b1;
    bus.IF_ID_Flush = 1'b0;
    bus.ID_Ex_Flush = 1'b0;
    if (rst) begin
      bus.PC_Write    = 1'b0;
      bus.IF_ID_Write = 1'b0;
      bus.IF_ID_Flush = 1'b1;
      bus.ID_Ex_Flush = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.mem_busy) begin
            bus.PC_Write    = 1'b0;
            bus.IF_ID_Write = 1'b0;
          end else if (n_req != 2'd0) begin
            bus.PC_Write    = 1'b0;
            bus.IF_ID_Write = 1'b0;
            bus.ID_Ex_Flush = 1'b1;
          end else if ((bus.IF_ID_Branch && bus.Branch_taken) || bus.Jump) begin
            bus.IF_ID_Flush = 1'b1;
          end
        end
        StStall: begin
          bus.PC_Write    = 1'b0;
          bus.IF_ID_Write = 1'b0;
          bus.ID_Ex_Flush = !bus.mem_busy;
        end
        default: begin
          bus.PC_Write    = 1'b0;
          bus.IF_ID_Write = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.ID_Ex_Flush && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (bus.IF_ID_Flush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_cnt_q;
  assign bus.flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: behavioural model checked every cycle plus literal checks.
module tb_hazard_sequencer;
  localparam int unsigned CntW   = 4;
  localparam int          CntMax = (1 << CntW) - 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   model_on;

  hazard_sequencer_if #(.CNT_W(CntW)) hz ();

  hazard_sequencer #(.CNT_W(CntW), .LD_BR_BUBBLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: bubbles still owed, frozen flag, event tallies.
  int m_pending;
  bit m_frozen;
  int m_stall;
  int m_flush;

  function automatic bit hits(input int r);
    return (r != 0) && (r == int'(hz.IF_ID_rs) || r == int'(hz.IF_ID_rt));
  endfunction

  function automatic int bubbles_needed();
    if (hz.IF_ID_Branch && hz.ID_Ex_RegWrite && hits(int'(hz.ID_Ex_wreg)))
      return hz.ID_Ex_MemRead ? 2 : 1;
    if (hz.IF_ID_Branch && hz.Ex_Mem_MemRead && hits(int'(hz.Ex_Mem_wreg))) return 1;
    if (!hz.IF_ID_Branch && hz.ID_Ex_MemRead && hits(int'(hz.ID_Ex_wreg))) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      int e_pc, e_ifw, e_iff, e_exf, n;
      e_pc = 1; e_ifw = 1; e_iff = 0; e_exf = 0;
      chk("stall_cycles", int'(hz.stall_cycles), m_stall);
      chk("flush_events", int'(hz.flush_events), m_flush);
      if (rst) begin
        e_pc = 0; e_ifw = 0; e_iff = 1; e_exf = 1;
      end else if (m_frozen || hz.mem_busy) begin
        e_pc = 0; e_ifw = 0;
      end else if (m_pending > 0) begin
        e_pc = 0; e_ifw = 0; e_exf = 1;
      end else begin
        n = bubbles_needed();
        if (n > 0) begin
          e_pc = 0; e_ifw = 0; e_exf = 1;
        end else if ((hz.IF_ID_Branch && hz.Branch_taken) || hz.Jump) begin
          e_iff = 1;
        end
      end
      chk("PC_Write", int'(hz.PC_Write), e_pc);
      chk("IF_ID_Write", int'(hz.IF_ID_Write), e_ifw);
      chk("IF_ID_Flush", int'(hz.IF_ID_Flush), e_iff);
      chk("ID_Ex_Flush", int'(hz.ID_Ex_Flush), e_exf);
      // Advance the model to the state after the coming clock edge.
      if (rst) begin
        m_pending = 0; m_frozen = 0; m_stall = 0; m_flush = 0;
      end else begin
        if (m_frozen) begin
          if (!hz.mem_busy) m_frozen = 0;
        end else if (hz.mem_busy) begin
          m_frozen = 1;
        end else if (m_pending > 0) begin
          m_pending--;
        end else if (e_exf == 1) begin
          m_pending = bubbles_needed() - 1;
        end
        if (e_exf == 1 && m_stall < CntMax) m_stall++;
        if (e_iff == 1 && m_flush < CntMax) m_flush++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.ID_Ex_MemRead  = 1'b0;
    hz.ID_Ex_RegWrite = 1'b0;
    hz.ID_Ex_wreg     = 5'd0;
    hz.Ex_Mem_MemRead = 1'b0;
    hz.Ex_Mem_wreg    = 5'd0;
    hz.IF_ID_rs       = 5'd0;
    hz.IF_ID_rt       = 5'd0;
    hz.IF_ID_Branch   = 1'b0;
    hz.Branch_taken   = 1'b0;
    hz.Jump           = 1'b0;
    hz.mem_busy       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_branch_hazard();
    hz.ID_Ex_MemRead  = 1'b1;
    hz.ID_Ex_RegWrite = 1'b1;
    hz.ID_Ex_wreg     = 5'd9;
    hz.IF_ID_Branch   = 1'b1;
    hz.IF_ID_rt       = 5'd9;
    hz.Branch_taken   = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; model_on = 0;
    m_pending = 0; m_frozen = 0; m_stall = 0; m_flush = 0;
    rst = 1'b1;
    clear_inputs();
    tick();
    model_on = 1;
    @(negedge clk);
    chk("rst PC_Write", int'(hz.PC_Write), 0);
    chk("rst IF_ID_Flush", int'(hz.IF_ID_Flush), 1);
    chk("rst ID_Ex_Flush", int'(hz.ID_Ex_Flush), 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst PC_Write", int'(hz.PC_Write), 1);
    chk("post-rst stall_cycles", int'(hz.stall_cycles), 0);

    // Load-use: one bubble, then run.
    tick();
    hz.ID_Ex_MemRead = 1'b1; hz.ID_Ex_wreg = 5'd8; hz.IF_ID_rs = 5'd8;
    @(negedge clk);
    chk("ldu PC_Write", int'(hz.PC_Write), 0);
    chk("ldu ID_Ex_Flush", int'(hz.ID_Ex_Flush), 1);
    tick();
    clear_inputs();
    @(negedge clk);
    chk("ldu after PC_Write", int'(hz.PC_Write), 1);
    chk("ldu stall_cycles", int'(hz.stall_cycles), 1);

    // $zero never hazards.
    tick();
    hz.ID_Ex_MemRead = 1'b1; hz.ID_Ex_wreg = 5'd0; hz.IF_ID_rs = 5'd0;
    @(negedge clk);
    chk("zero PC_Write", int'(hz.PC_Write), 1);
    chk("zero ID_Ex_Flush", int'(hz.ID_Ex_Flush), 0);

    // ALU result feeding a branch, then MEM-stage load feeding a branch: one bubble each.
    tick();
    clear_inputs();
    hz.IF_ID_Branch = 1'b1; hz.ID_Ex_RegWrite = 1'b1; hz.ID_Ex_wreg = 5'd5; hz.IF_ID_rs = 5'd5;
    tick();
    clear_inputs();
    hz.IF_ID_Branch = 1'b1; hz.Ex_Mem_MemRead = 1'b1; hz.Ex_Mem_wreg = 5'd7; hz.IF_ID_rt = 5'd7;
    tick();
    clear_inputs();

    // Load then taken branch: two bubbles, then one squash.
    do_reset();
    load_branch_hazard();
    @(negedge clk);
    chk("ldbr b1 ID_Ex_Flush", int'(hz.ID_Ex_Flush), 1);
    tick();
    @(negedge clk);
    chk("ldbr b2 ID_Ex_Flush", int'(hz.ID_Ex_Flush), 1);
    tick();
    hz.ID_Ex_MemRead = 1'b0; hz.ID_Ex_RegWrite = 1'b0;
    @(negedge clk);
    chk("ldbr squash IF_ID_Flush", int'(hz.IF_ID_Flush), 1);
    chk("ldbr stall_cycles", int'(hz.stall_cycles), 2);
    tick();
    clear_inputs();
    @(negedge clk);
    chk("ldbr flush_events", int'(hz.flush_events), 1);
    chk("ldbr single squash", int'(hz.IF_ID_Flush), 0);

    // Freeze after first bubble: 3 busy + 1 release cycle, then the last bubble.
    do_reset();
    load_branch_hazard();
    tick();
    hz.mem_busy = 1'b1;
    @(negedge clk);
    chk("frz ID_Ex_Flush", int'(hz.ID_Ex_Flush), 0);
    chk("frz PC_Write", int'(hz.PC_Write), 0);
    tick();
    tick();
    tick();
    hz.mem_busy = 1'b0;
    @(negedge clk);
    chk("frz release ID_Ex_Flush", int'(hz.ID_Ex_Flush), 0);
    tick();
    @(negedge clk);
    chk("frz last bubble", int'(hz.ID_Ex_Flush), 1);
    tick();
    clear_inputs();
    @(negedge clk);
    chk("frz stall_cycles", int'(hz.stall_cycles), 2);
    chk("frz resume PC_Write", int'(hz.PC_Write), 1);

    // Jump held 20 cycles: counter saturates.
    do_reset();
    hz.Jump = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    hz.Jump = 1'b0;
    @(negedge clk);
    chk("jmp flush_events sat", int'(hz.flush_events), 15);

    // Reset while a bubble is still owed.
    do_reset();
    load_branch_hazard();
    tick();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rststall PC_Write", int'(hz.PC_Write), 1);
    chk("rststall ID_Ex_Flush", int'(hz.ID_Ex_Flush), 0);
    chk("rststall IF_ID_Flush", int'(hz.IF_ID_Flush), 0);
    chk("rststall stall_cycles", int'(hz.stall_cycles), 0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
